mult_add_16: RTL and testbench

Sequential multiply-accumulate engine computing `o_result = i_addend + i_multiplicand * i_multiplier` by shift-and-add. It is the inverse of the team's repeated-subtraction divider: it rebuilds a value from quotient × step + offset, e.g. a distance or pulse position from a bin index. It sits beside the divider in the 50 MHz processing domain and uses the same single-pulse `i_cal_sig` / `o_cal_done` handshake.

---
 rtl/mult_add_pkg.sv | 24 ++
 rtl/mult_add_16.sv | 160 ++++++++++++++++
 tb/tb_mult_add_16.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_add_pkg
//  Description : Shared definitions for the mult_add_16 shift-and-add
//                multiply-accumulate engine. It holds the one-hot controller
//                state encodings and the default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_add_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // One-hot controller states. This is the same handshake flow that the
  // companion divider uses.
  typedef enum logic [4:0] {
    CAL_IDLE   = 5'b00001,
    CAL_ASSIGN = 5'b00010,
    CAL_CALC   = 5'b00100,
    CAL_END    = 5'b01000,
    CAL_OVER   = 5'b10000
  } cal_state_t;

endpackage
`default_nettype wire

// File: rtl/mult_add_16.sv
`default_nettype none
// ============================================================================
//  Module      : mult_add_16
//  Description : Sequential multiply-accumulate engine that computes
//                o_result = i_addend + i_multiplicand * i_multiplier
//                by shift-and-add, one multiplier bit per clock. When either
//                factor is zero, the engine skips CALC and returns the addend.
//  Ports       : i_clk_50m      - system clock (rising edge)
//                i_rst          - asynchronous active-high reset
//                i_cal_sig      - start request, sampled only in IDLE
//                i_multiplicand - step size, latched in ASSIGN
//                i_multiplier   - count / index, latched in ASSIGN
//                i_addend       - offset, latched in ASSIGN
//                o_result       - 2*WIDTH result, held until the next END
//                o_sat          - saturation flag, updated in END
//                o_cal_done     - one-cycle completion pulse
//  Config      : MULT_ADD_SAT_EN - when defined, the result is clamped to
//                2^WIDTH-1 and o_sat is raised. When undefined, the full
//                product-sum is returned and o_sat is held at 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_add_16
  import mult_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 i_clk_50m,
  input  logic                 i_rst,
  input  logic                 i_cal_sig,
  input  logic [WIDTH-1:0]     i_multiplicand,
  input  logic [WIDTH-1:0]     i_multiplier,
  input  logic [WIDTH-1:0]     i_addend,
  output logic [2*WIDTH-1:0]   o_result,
  output logic                 o_sat,
  output logic                 o_cal_done
);

  localparam int                 CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(WIDTH - 1);

  cal_state_t               state;
  cal_state_t               next_state;
  logic [2*WIDTH-1:0]       acc;
  logic [2*WIDTH-1:0]       mcand;
  logic [WIDTH-1:0]         mplier;
  logic [CNT_W-1:0]         iter_cnt;
  logic                     last_iter;
  logic                     zero_operand;

  // The iteration that shifts the final set bit out of mplier is the last
  // one. The counter bound is a backstop, and it never fires for legal
  // operands.
  assign last_iter    = (mplier[WIDTH-1:1] == '0) || (iter_cnt == LAST_ITER);
  assign zero_operand = (i_multiplicand == '0) || (i_multiplier == '0);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      state <= CAL_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Any encoding that is not one-hot falls back to IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = CAL_IDLE;
    case (state)
      CAL_IDLE:   next_state = i_cal_sig ? CAL_ASSIGN : CAL_IDLE;
      CAL_ASSIGN: next_state = zero_operand ? CAL_END : CAL_CALC;
      CAL_CALC:   next_state = last_iter ? CAL_END : CAL_CALC;
      CAL_END:    next_state = CAL_OVER;
      CAL_OVER:   next_state = CAL_IDLE;
      default:    next_state = CAL_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: accumulator, shifting multiplicand and multiplier.
  // The maximum sum (2^W-1)^2 + (2^W-1) = 2^2W - 2^W fits in acc, so the
  // addition cannot wrap.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      iter_cnt <= '0;
    end else begin
      case (state)
        CAL_IDLE: begin
          acc      <= '0;
          mcand    <= '0;
          mplier   <= '0;
          iter_cnt <= '0;
        end
        CAL_ASSIGN: begin
          acc    <= {{WIDTH{1'b0}}, i_addend};
          mcand  <= {{WIDTH{1'b0}}, i_multiplicand};
          mplier <= i_multiplier;
        end
        CAL_CALC: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand    <= mcand << 1;
          mplier   <= mplier >> 1;
          iter_cnt <= iter_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Result and completion pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      o_cal_done <= 1'b0;
    end else begin
      o_cal_done <= (state == CAL_END);
    end
  end

`ifdef MULT_ADD_SAT_EN
  localparam logic [2*WIDTH-1:0] SAT_MAX = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};

  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      o_result <= '0;
      o_sat    <= 1'b0;
    end else if (state == CAL_END) begin
      if (acc > SAT_MAX) begin
        o_result <= SAT_MAX;
        o_sat    <= 1'b1;
      end else begin
        o_result <= acc;
        o_sat    <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      o_result <= '0;
    end else if (state == CAL_END) begin
      o_result <= acc;
    end
  end

  assign o_sat = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_add_16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_add_16
//  Description : Self-checking bench for mult_add_16. It applies table
//                vectors, hand-built busy/reset/back-to-back sequences, and
//                random operands, and compares them against an arithmetic
//                reference model. It honours MULT_ADD_SAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_add_16;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cal_sig = 1'b0;
  logic [W-1:0]  mcand_in = '0;
  logic [W-1:0]  mplier_in = '0;
  logic [W-1:0]  addend_in = '0;
  logic [2*W-1:0] result;
  logic          sat;
  logic          cal_done;

  int checks = 0;
  int errors = 0;

  mult_add_16 #(.WIDTH(W)) dut (
    .i_clk_50m      (clk),
    .i_rst          (rst),
    .i_cal_sig      (cal_sig),
    .i_multiplicand (mcand_in),
    .i_multiplier   (mplier_in),
    .i_addend       (addend_in),
    .o_result       (result),
    .o_sat          (sat),
    .o_cal_done     (cal_done)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the full product-sum, optionally clamped. Returns {sat, result}.
  function automatic logic [32:0] apply_cfg(input logic [63:0] full);
`ifdef MULT_ADD_SAT_EN
    if (full > 64'h0000_FFFF) return {1'b1, 32'h0000_FFFF};
`endif
    return {1'b0, full[31:0]};
  endfunction

  function automatic logic [32:0] model(input logic [15:0] mc, input logic [15:0] mp,
                                        input logic [15:0] ad);
    logic [63:0] full;
    full = 64'(ad) + 64'(mc) * 64'(mp);
    return apply_cfg(full);
  endfunction

  // Edge on which done becomes visible: 3 for a zero operand, else 3 + k,
  // where k is the multiplier's bit length.
  function automatic int model_edge(input logic [15:0] mc, input logic [15:0] mp);
    int k;
    k = 0;
    if (mc == 16'd0 || mp == 16'd0) return 3;
    for (int i = 0; i < 16; i++) if (mp[i]) k = i + 1;
    return 3 + k;
  endfunction

  // Run one operation. Edge 1 samples cal_sig. The task returns the result,
  // the sat flag and the edge where done appeared (-1 on timeout). It also
  // checks that done drops again one cycle later.
  task automatic do_op(input string name, input logic [15:0] mc, input logic [15:0] mp,
                       input logic [15:0] ad, output logic [31:0] res, output logic s,
                       output int edge_n);
    @(negedge clk);
    cal_sig   = 1'b1;
    mcand_in  = mc;
    mplier_in = mp;
    addend_in = ad;
    @(posedge clk);
    @(negedge clk);
    cal_sig = 1'b0;
    edge_n = -1;
    for (int n = 2; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (cal_done) begin
        edge_n = n;
        break;
      end
    end
    res = result;
    s   = sat;
    @(posedge clk);
    #1;
    check({name, "_done_width"}, 64'(cal_done), 64'd0);
  endtask

  typedef struct {
    string       name;
    logic [15:0] mc;
    logic [15:0] mp;
    logic [15:0] ad;
    logic [63:0] exp_full;
    int          exp_edge;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] res;
    logic        s;
    int          edge_n;
    logic [32:0] exp;
    int          pulses;
    int          first_edge;
    logic [31:0] first_res;

    vecs[0] = '{"basic",     16'd100,    16'd37,     16'd5,      64'd3705,        9};
    vecs[1] = '{"zero_mp",   16'h1234,   16'h0000,   16'd7,      64'd7,           3};
    vecs[2] = '{"zero_mc",   16'h0000,   16'h0055,   16'd9,      64'd9,           3};
    vecs[3] = '{"max",       16'hFFFF,   16'hFFFF,   16'hFFFF,   64'hFFFF_0000,   19};
    vecs[4] = '{"one",       16'd1,      16'd1,      16'd0,      64'd1,           4};
    vecs[5] = '{"msb_only",  16'd3,      16'h8000,   16'd0,      64'h0001_8000,   19};
    vecs[6] = '{"small",     16'd3,      16'd4,      16'd1,      64'd13,          6};
    vecs[7] = '{"sat_edge",  16'h00FF,   16'h00FF,   16'h01FE,   64'h0000_FFFF,   11};
    vecs[8] = '{"sat_over",  16'h00FF,   16'h00FF,   16'h01FF,   64'h0001_0000,   11};

    // Reset state
    #5;
    check("reset_result", 64'(result), 64'd0);
    check("reset_sat", 64'(sat), 64'd0);
    check("reset_done", 64'(cal_done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].name, vecs[i].mc, vecs[i].mp, vecs[i].ad, res, s, edge_n);
      exp = apply_cfg(vecs[i].exp_full);
      check({vecs[i].name, "_result"}, 64'(res), 64'(exp[31:0]));
      check({vecs[i].name, "_sat"}, 64'(s), 64'(exp[32]));
      check({vecs[i].name, "_edge"}, 64'(edge_n), 64'(vecs[i].exp_edge));
    end

    // Start while busy: a second request and new operands during CALC must
    // be ignored.
    @(negedge clk);
    cal_sig = 1'b1; mcand_in = 16'd100; mplier_in = 16'd37; addend_in = 16'd5;
    @(posedge clk);
    @(negedge clk);
    cal_sig = 1'b0;
    pulses = 0; first_edge = -1; first_res = '0;
    for (int n = 2; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (cal_done) begin
        pulses++;
        if (first_edge < 0) begin
          first_edge = n;
          first_res  = result;
        end
      end
      if (n == 3) begin
        cal_sig = 1'b1; mcand_in = 16'h0BAD; mplier_in = 16'h00F3; addend_in = 16'h0011;
      end
      if (n == 4) cal_sig = 1'b0;
    end
    check("busy_pulses", 64'(pulses), 64'd1);
    check("busy_edge", 64'(first_edge), 64'd9);
    check("busy_result", 64'(first_res), 64'(model(16'd100, 16'd37, 16'd5) & 33'h0_FFFF_FFFF));
    check("busy_result_held", 64'(result), 64'd3705);

    // Reset in the middle of CALC
    @(negedge clk);
    cal_sig = 1'b1; mcand_in = 16'hFFFF; mplier_in = 16'hFFFF; addend_in = 16'd0;
    @(posedge clk);
    @(negedge clk);
    cal_sig = 1'b0;
    repeat (4) @(posedge clk);
    #5;
    rst = 1'b1;
    #1;
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_sat", 64'(sat), 64'd0);
    check("midrst_done", 64'(cal_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (cal_done) pulses++;
    end
    check("midrst_no_done", 64'(pulses), 64'd0);
    do_op("after_rst", 16'd3, 16'd4, 16'd1, res, s, edge_n);
    check("after_rst_result", 64'(res), 64'd13);
    check("after_rst_edge", 64'(edge_n), 64'd6);

    // Back-to-back: restart right after OVER. The old result must stay held
    // until the new END.
    do_op("b2b_first", 16'd7, 16'd9, 16'd0, res, s, edge_n);
    check("b2b_first_result", 64'(res), 64'd63);
    @(negedge clk);
    cal_sig = 1'b1; mcand_in = 16'd2; mplier_in = 16'd2; addend_in = 16'd0;
    @(posedge clk);
    @(negedge clk);
    cal_sig = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("b2b_hold_result", 64'(result), 64'd63);
      check("b2b_hold_done", 64'(cal_done), 64'd0);
    end
    @(posedge clk);
    #1;
    check("b2b_done", 64'(cal_done), 64'd1);
    check("b2b_result", 64'(result), 64'd4);
    @(posedge clk);
    #1;
    check("b2b_done_width", 64'(cal_done), 64'd0);

    // Random operands against the reference model
    for (int t = 0; t < 24; t++) begin
      logic [15:0] mc, mp, ad;
      mc = 16'($urandom);
      mp = 16'($urandom);
      ad = 16'($urandom);
      if ($urandom_range(0, 7) == 0) mc = '0;
      if ($urandom_range(0, 7) == 0) mp = '0;
      if ($urandom_range(0, 3) == 0) mp = mp >> $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) mc = mc >> $urandom_range(4, 15);
      do_op("rand", mc, mp, ad, res, s, edge_n);
      exp = model(mc, mp, ad);
      check("rand_result", 64'(res), 64'(exp[31:0]));
      check("rand_sat", 64'(s), 64'(exp[32]));
      check("rand_edge", 64'(edge_n), 64'(model_edge(mc, mp)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
